uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
// - Command sequencer behind UART_RX. Consumes received bytes (P_DATA/data_valid plus error flags).
// - Parses command frames and drives register-file write/read and ALU operations.
// - Returns read/ALU results as bytes on a valid/ready stream toward the TX path.
// - Same clock domain as UART_RX; data_valid is a 1-cycle pulse.
// PARAMETERS
// - DATA_WIDTH      8     byte width of RX/TX/RF data
// - ADDR_WIDTH      4     register-file address width
// - TIMEOUT_CYCLES  4096  inter-byte timeout; used only with UART_CMD_TIMEOUT_EN
// PORTS
// - CLK            in   1             system clock
// - RST            in   1             synchronous, active-high reset
// - P_DATA         in   DATA_WIDTH    received byte
// - data_valid     in   1             byte strobe, 1 cycle
// - PARITY_ERROR   in   1             RX parity error pulse
// - FRAME_ERROR    in   1             RX framing error pulse
// - RF_WR_EN       out  1             register-file write strobe, 1 cycle
// - RF_RD_EN       out  1             register-file read strobe, 1 cycle
// - RF_ADDR        out  ADDR_WIDTH    register-file address
// - RF_WR_DATA     out  DATA_WIDTH    register-file write data
// - RF_RD_DATA     in   DATA_WIDTH    register-file read data
// - RF_RD_VALID    in   1             read data valid, 1 cycle
// - ALU_EN         out  1             ALU start strobe, 1 cycle
// - ALU_FUN        out  4             ALU function code
// - ALU_OUT        in   2*DATA_WIDTH  ALU result
// - ALU_OUT_VALID  in   1             ALU result valid, 1 cycle
// - TX_DATA        out  DATA_WIDTH    response byte
// - TX_VALID       out  1             response byte valid
// - TX_READY       in   1             TX path accepts byte
// - BUSY           out  1             high in every state except IDLE
// - CMD_ERR        out  1             1-cycle pulse on any aborted or dropped byte
// - ERR_CNT        out  8             saturating error count
// BEHAVIOUR
// - Reset: RST high at a CLK edge forces IDLE and zeroes all outputs and counters, mid-frame included. A pending RF/ALU/TX transaction is dropped with no further strobes.
// - Command frames, all bytes via data_valid:
//   - 0xAA  write: ADDR, DATA.
//   - 0xBB  read: ADDR.
//   - 0xCC  ALU: A, B, FUN.
//   - 0xDD  ALU: FUN only.
// - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
// - IDLE: AA->WR_ADDR, BB->RD_ADDR, CC->ALU_A, DD->ALU_FUN. Any other byte -> CMD_ERR, stay IDLE.
// - Address bytes: P_DATA[ADDR_WIDTH-1:0] latched; upper bits ignored.
// - WR_DATA byte: the next cycle drives RF_WR_EN=1 with RF_ADDR/RF_WR_DATA, then IDLE. No TX.
// - RD_ADDR byte: the next cycle drives RF_RD_EN=1, then RD_WAIT. On RF_RD_VALID, latch RF_RD_DATA -> TX_HI (single-byte response).
// - ALU_A byte: the next cycle writes RF addr 0. ALU_B byte: the next cycle writes RF addr 1. Then ALU_FUN.
// - ALU_FUN byte: the next cycle drives ALU_EN=1 with ALU_FUN=P_DATA[3:0], then ALU_WAIT. On ALU_OUT_VALID, latch ALU_OUT -> TX_LO.
// - TX handshake:
//   - TX_LO sends result[7:0], then TX_HI sends the high byte (ALU), or the read byte (read).
//   - TX_VALID and TX_DATA hold stable until TX_VALID&&TX_READY; the transfer completes in that cycle.
//   - TX_LO->TX_HI; TX_HI->IDLE.
// - Error flags: PARITY_ERROR|FRAME_ERROR high in any cycle aborts to IDLE with CMD_ERR and no RF/ALU strobe for the partial frame. In IDLE they only set CMD_ERR.
// - data_valid in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: byte dropped, CMD_ERR pulses, state unchanged.
// - data_valid and an error flag in the same cycle: the error wins, and the byte is dropped.
// - ERR_CNT increments on every CMD_ERR pulse and saturates at 8'hFF.
// - RF_RD_VALID/ALU_OUT_VALID outside the matching wait state: ignored.
// CONFIGURATION
// - UART_CMD_TIMEOUT_EN defined:
//   - Counter restarts on each accepted byte in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_FUN.
//   - TIMEOUT_CYCLES cycles with no byte -> IDLE, with a CMD_ERR pulse and an ERR_CNT increment.
//   - Wait and TX states never time out.
// - UART_CMD_TIMEOUT_EN undefined: no counter; argument states wait indefinitely.
// TESTING
// - RX AA,05,3C -> single RF_WR_EN cycle with ADDR=5, WR_DATA=3C; TX_VALID stays 0; BUSY then returns 0.
// - RX BB,05; RF_RD_VALID with 3C 2 cycles after RF_RD_EN; TX_READY low for 5 cycles -> TX_DATA=3C held, exactly one transfer.
// - RX CC,07,03,00; ALU_OUT=000A -> RF writes addr0=07 and addr1=03, ALU_EN with FUN=0, TX bytes 0A then 00.
// - RX AA, then a byte with PARITY_ERROR -> IDLE, CMD_ERR, ERR_CNT=1, no RF_WR_EN. Then AA,01,FF writes addr1=FF.
// - 300 bytes of 0x55 in IDLE -> 300 CMD_ERR pulses, ERR_CNT=FF. Then RST high for 1 cycle during ALU_WAIT -> all outputs 0, ERR_CNT=0.
// - RX AA,05 then silence -> with macro: IDLE plus CMD_ERR after TIMEOUT_CYCLES; without macro: BUSY stays 1.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - command frame sequencer between UART RX, register file, ALU and TX stream
// Optional inter-byte timeout in argument states: define UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   P_DATA,
  input  logic                    data_valid,
  input  logic                    PARITY_ERROR,
  input  logic                    FRAME_ERROR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VALID,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic                    BUSY,
  output logic                    CMD_ERR,
  output logic [7:0]              ERR_CNT
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU     = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_FUN = DATA_WIDTH'(8'hDD);

  state_t                state;
  logic [DATA_WIDTH-1:0] res_hi;
  logic                  is_cmd;
  logic                  drop_err;
  logic                  abort;
  logic                  timeout;

  assign BUSY   = (state != S_IDLE);
  assign is_cmd = (P_DATA == CMD_WR) || (P_DATA == CMD_RD) ||
                  (P_DATA == CMD_ALU) || (P_DATA == CMD_ALU_FUN);
  assign abort  = PARITY_ERROR | FRAME_ERROR | timeout;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          arg_state;

  assign arg_state = (state == S_WR_ADDR) || (state == S_WR_DATA) || (state == S_RD_ADDR) ||
                     (state == S_ALU_A) || (state == S_ALU_B) || (state == S_ALU_FUN);

  // Restarts on every byte so only silence between bytes of a frame is timed
  always_ff @(posedge CLK) begin
    if (RST || !arg_state || data_valid)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign timeout = arg_state && !data_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Bytes that cannot be consumed in the current state are reported, not acted on
  always_comb begin
    drop_err = 1'b0;
    if (data_valid) begin
      case (state)
        S_IDLE:                                  drop_err = !is_cmd;
        S_RD_WAIT, S_ALU_WAIT, S_TX_LO, S_TX_HI: drop_err = 1'b1;
        default:                                 drop_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      res_hi     <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      TX_DATA    <= '0;
      TX_VALID   <= 1'b0;
      CMD_ERR    <= 1'b0;
      ERR_CNT    <= '0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      CMD_ERR  <= 1'b0;
      if (abort || drop_err) begin
        CMD_ERR <= 1'b1;
        if (ERR_CNT != 8'hFF)
          ERR_CNT <= ERR_CNT + 8'd1;
      end
      if (abort) begin
        state    <= S_IDLE;
        TX_VALID <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (data_valid) begin
            if (P_DATA == CMD_WR)           state <= S_WR_ADDR;
            else if (P_DATA == CMD_RD)      state <= S_RD_ADDR;
            else if (P_DATA == CMD_ALU)     state <= S_ALU_A;
            else if (P_DATA == CMD_ALU_FUN) state <= S_ALU_FUN;
          end
          S_WR_ADDR: if (data_valid) begin
            RF_ADDR <= P_DATA[ADDR_WIDTH-1:0];
            state   <= S_WR_DATA;
          end
          S_WR_DATA: if (data_valid) begin
            RF_WR_DATA <= P_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= S_IDLE;
          end
          S_RD_ADDR: if (data_valid) begin
            RF_ADDR  <= P_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
            state    <= S_RD_WAIT;
          end
          // Read responses are a single byte, so they go straight to the final TX slot
          S_RD_WAIT: if (RF_RD_VALID) begin
            TX_DATA  <= RF_RD_DATA;
            TX_VALID <= 1'b1;
            state    <= S_TX_HI;
          end
          S_ALU_A: if (data_valid) begin
            RF_ADDR    <= '0;
            RF_WR_DATA <= P_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= S_ALU_B;
          end
          S_ALU_B: if (data_valid) begin
            RF_ADDR    <= ADDR_WIDTH'(1);
            RF_WR_DATA <= P_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= S_ALU_FUN;
          end
          S_ALU_FUN: if (data_valid) begin
            ALU_FUN <= P_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= S_ALU_WAIT;
          end
          S_ALU_WAIT: if (ALU_OUT_VALID) begin
            TX_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
            res_hi   <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            TX_VALID <= 1'b1;
            state    <= S_TX_LO;
          end
          S_TX_LO: if (TX_VALID && TX_READY) begin
            TX_DATA <= res_hi;
            state   <= S_TX_HI;
          end
          S_TX_HI: if (TX_VALID && TX_READY) begin
            TX_VALID <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
